// File: rtl/lut_target_table.sv
// lut_target_table: runtime-writable branch-target table with registered lookup and clear sweep.
// Optional macro LUT_TGT_BYPASS_EN forwards a same-cycle write/invalidate to a same-index lookup.
module lut_target_table #(
    parameter int ADDR_W = 4,
    parameter int TGT_W = 8,
    parameter logic [TGT_W-1:0] DEFAULT_TARGET = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [TGT_W-1:0]  o_target,
    output logic              o_hit,
    output logic              o_rd_valid,
    input  logic              i_wr_en,
    input  logic              i_wr_inv,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [TGT_W-1:0]  i_wr_data,
    input  logic              i_clear_req,
    output logic              o_busy
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [0:0] S_SWEEP = 1'b0;
    localparam logic [0:0] S_RUN = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W:0]   r_ptr;
    logic [TGT_W-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [TGT_W-1:0]  r_target;
    logic              r_hit;
    logic              r_rd_valid;

    logic              w_run;
    logic              w_wr;
    logic              w_inv;
    logic              w_last;
    logic [ADDR_W-1:0] w_ptr;
    logic [TGT_W-1:0]  w_rd_data;
    logic              w_rd_hit;

    // ClearReq pre-empts any write issued in the same cycle
    assign w_run  = r_state == S_RUN;
    assign w_wr   = w_run & i_wr_en & ~i_clear_req;
    assign w_inv  = w_run & i_wr_inv & ~i_wr_en & ~i_clear_req;
    assign w_ptr  = r_ptr[ADDR_W-1:0];
    assign w_last = r_ptr == (ADDR_W+1)'(DEPTH-1);

`ifdef LUT_TGT_BYPASS_EN
    logic w_byp_wr;
    logic w_byp_inv;
    assign w_byp_wr  = w_wr && (i_wr_addr == i_addr);
    assign w_byp_inv = w_inv && (i_wr_addr == i_addr);
    assign w_rd_data = w_byp_wr ? i_wr_data : r_mem[i_addr];
    assign w_rd_hit  = w_byp_wr | (~w_byp_inv & r_valid[i_addr]);
`else
    assign w_rd_data = r_mem[i_addr];
    assign w_rd_hit  = r_valid[i_addr];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_SWEEP;
            r_ptr   <= '0;
        end else if (i_clear_req) begin
            r_state <= S_SWEEP;
            r_ptr   <= '0;
        end else if (!w_run) begin
            r_ptr <= r_ptr + (ADDR_W+1)'(1);
            if (w_last) r_state <= S_RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_valid <= '0;
        else if (!w_run) r_valid[w_ptr] <= 1'b0;
        else if (w_wr) r_valid[i_wr_addr] <= 1'b1;
        else if (w_inv) r_valid[i_wr_addr] <= 1'b0;
    end

    // Table data has no reset; the sweep initialises it
    always_ff @(posedge i_clk) begin
        if (!w_run) r_mem[w_ptr] <= DEFAULT_TARGET;
        else if (w_wr) r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target   <= '0;
            r_hit      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_target <= w_run ? w_rd_data : DEFAULT_TARGET;
                r_hit    <= w_run & w_rd_hit;
            end
        end
    end

    assign o_target   = r_target;
    assign o_hit      = r_hit;
    assign o_rd_valid = r_rd_valid;
    assign o_busy     = ~w_run;
endmodule

// File: tb/tb_lut_target_table.sv
// tb_lut_target_table: randomized scoreboard bench for lut_target_table against a table-level model.
module tb_lut_target_table;
    localparam int AW = 4;
    localparam int TW = 8;
    localparam int D = 16;
    localparam logic [TW-1:0] DEF = 8'h00;

    logic clk = 1'b0, rst_n = 1'b0;
    logic rd_en = 1'b0, wr_en = 1'b0, wr_inv = 1'b0, clear_req = 1'b0;
    logic [AW-1:0] addr = '0, wr_addr = '0;
    logic [TW-1:0] wr_data = '0;
    logic [TW-1:0] target;
    logic hit, rd_valid, busy;

    lut_target_table #(.ADDR_W(AW), .TGT_W(TW), .DEFAULT_TARGET(DEF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_addr(addr),
        .o_target(target), .o_hit(hit), .o_rd_valid(rd_valid),
        .i_wr_en(wr_en), .i_wr_inv(wr_inv), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_clear_req(clear_req), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [TW:0] q[$];
    logic [TW:0] m_last = '0;
    logic [TW-1:0] m_mem [D];
    bit m_val [D];
    int sweep_left = D;
    bit exp_busy = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void enter_sweep();
        foreach (m_mem[i]) begin
            m_mem[i] = DEF;
            m_val[i] = 1'b0;
        end
        sweep_left = D;
    endfunction

    task automatic apply(input bit rd, input logic [AW-1:0] a, input bit we, input bit inv,
                         input logic [AW-1:0] wa, input logic [TW-1:0] wd, input bit clr);
        rd_en = rd; addr = a; wr_en = we; wr_inv = inv; wr_addr = wa; wr_data = wd; clear_req = clr;
        if (sweep_left > 0) begin
            if (rd) q.push_back({1'b0, DEF});
        end else begin
            if (rd) begin
`ifdef LUT_TGT_BYPASS_EN
                if (we && !clr && wa == a) q.push_back({1'b1, wd});
                else if (inv && !we && !clr && wa == a) q.push_back({1'b0, m_mem[a]});
                else
`endif
                q.push_back({m_val[a], m_mem[a]});
            end
            if (!clr) begin
                if (we) begin
                    m_mem[wa] = wd;
                    m_val[wa] = 1'b1;
                end else if (inv) m_val[wa] = 1'b0;
            end
        end
        if (clr) enter_sweep();
        else if (sweep_left > 0) sweep_left--;
        exp_busy = sweep_left > 0;
    endtask

    task automatic drive(input bit rd, input logic [AW-1:0] a, input bit we, input bit inv,
                         input logic [AW-1:0] wa, input logic [TW-1:0] wd, input bit clr);
        @(negedge clk); #1;
        apply(rd, a, we, inv, wa, wd, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read(input logic [AW-1:0] a);
        drive(1, a, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        rd_en = 0; wr_en = 0; wr_inv = 0; clear_req = 0;
        q.delete();
        m_last = '0;
        enter_sweep();
        exp_busy = 1'b1;
        #1;
        check("rst_target", target, 0);
        check("rst_hit", hit, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 1);
        @(negedge clk); #1;
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, exp_busy);
            if (q.size() != 0) begin
                m_last = q.pop_front();
                check("rd_valid_hi", rd_valid, 1);
                check("target", target, m_last[TW-1:0]);
                check("hit", hit, m_last[TW]);
            end else begin
                check("rd_valid_lo", rd_valid, 0);
                check("hold", {hit, target}, m_last);
            end
        end
    end

    initial begin
        enter_sweep();
        repeat (2) @(negedge clk);
        #1;
        check("init_target", target, 0);
        check("init_busy", busy, 1);
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0);
        idle(16);
        read(5);
        drive(0, 0, 1, 0, 2, 8'd235, 0);
        drive(0, 0, 1, 0, 7, 8'd4, 0);
        read(2);
        read(7);
        drive(0, 0, 0, 1, 2, 0, 0);
        read(2);
        drive(0, 0, 1, 1, 3, 8'd129, 0);
        read(3);
        drive(1, 4, 1, 0, 4, 8'd210, 0);
        read(4);
        drive(0, 0, 1, 0, 6, 8'd165, 0);
        drive(1, 6, 1, 0, 6, 8'd77, 1);
        drive(1, 6, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 6, 8'd99, 0);
        drive(0, 0, 0, 1, 6, 0, 0);
        drive(1, 2, 1, 0, 1, 8'd55, 0);
        drive(0, 0, 1, 0, 6, 8'd11, 1);
        idle(20);
        read(6);
        read(1);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        do_reset();
        idle(18);
        read(0);
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a, wa;
            a = AW'($urandom_range(0, D - 1));
            wa = $urandom_range(0, 1) ? a : AW'($urandom_range(0, D - 1));
            if ($urandom_range(0, 299) == 0) do_reset();
            else drive($urandom_range(0, 1), a, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
                       wa, TW'($urandom), $urandom_range(0, 79) == 0);
        end
        idle(3);
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lut_target_table.md
# lut_target_table

Parametrised, runtime-writable branch-target table for the processor's fetch/branch path. The next generation of the fixed jump LUT: instead of hard-coded targets, a loader writes targets into a DEPTH-entry table with per-entry valid bits, and the fetch unit reads them with a registered one-cycle lookup. A built-in clear sequencer sweeps the table after reset or on request. The block sits between the instruction decoder (which supplies the LUT index) and the program counter (which consumes Target).

## Interface

- ADDR_W, 4: index width; DEPTH = 2**ADDR_W entries.
- TGT_W, 8: target (PC) width.
- DEFAULT_TARGET, 0: value written into every entry by the clear sweep.

- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- RdEn  in  1  lookup request.
- Addr  in  ADDR_W  lookup index.
- Target  out  TGT_W  registered lookup result.
- Hit  out  1  registered: looked-up entry was valid.
- RdValid  out  1  registered: Target/Hit correspond to an accepted lookup.
- WrEn  in  1  write WrData into entry WrAddr and mark it valid.
- WrInv  in  1  clear valid bit of entry WrAddr.
- WrAddr  in  ADDR_W  write/invalidate index.
- WrData  in  TGT_W  target to store.
- ClearReq  in  1  one-cycle pulse: restart the clear sweep.
- Busy  out  1  high while the clear sweep runs.

## Operation

- FSM states: SWEEP, RUN.
- SWEEP: pointer starts at 0; each cycle writes DEFAULT_TARGET to entry[ptr], clears valid[ptr], increments ptr. After entry DEPTH-1 is written, moves to RUN. Busy=1 throughout SWEEP.
- RUN: Busy=0; lookups and writes accepted.
- ClearReq in either state: pointer reset to 0, enter SWEEP next cycle (restarts an in-progress sweep).
- During SWEEP: WrEn/WrInv ignored; RdEn accepted but forced RdValid=1, Hit=0, Target=DEFAULT_TARGET.
- Lookup (RUN, RdEn=1): next cycle Target=entry[Addr], Hit=valid[Addr], RdValid=1. RdEn=0: RdValid=0 next cycle, Target/Hit hold.
- Miss (valid=0): Target still returns stored data (DEFAULT_TARGET after sweep or last stale value after WrInv); consumer must qualify with Hit.
- WrEn and WrInv same cycle: WrEn wins, WrInv ignored.
- ClearReq with WrEn same cycle: ClearReq wins; the write is dropped.
- Lookup and write to the same index same cycle: see Configuration.
- Widths: no arithmetic on data; pointer is ADDR_W+1 bits to detect sweep completion, no wrap.

## Timing

- Reset (async assert): state=SWEEP, ptr=0, Busy=1, Target=0, Hit=0, RdValid=0; all valid bits cleared. Table data is not reset; the sweep initialises it.
- After Reset_n deasserts: sweep takes exactly DEPTH cycles; Busy falls on the cycle after entry DEPTH-1 is written.
- Read latency: 1 cycle (request at edge N, result valid after edge N+1).
- Write latency: entry updated at the edge where WrEn is sampled; a lookup issued the following cycle returns the new data.
- Reset asserted mid-sweep or mid-RUN: immediate return to reset values; the sweep restarts from 0.

## Configuration

- LUT_TGT_BYPASS_EN defined: a lookup to the index being written (WrEn=1, WrAddr==Addr, RUN) returns WrData with Hit=1; a same-index WrInv returns Hit=0.
- Undefined: same-cycle lookup returns pre-write contents and valid bit; the write still takes effect.

## Test plan

- Reset, then hold idle: Busy=1 for exactly 16 cycles (ADDR_W=4), then 0; lookup of index 5 -> Target=0, Hit=0, RdValid=1.
- Write index 2=235, index 7=4; look up 2 then 7 -> Target 235 then 4, Hit=1 each, one cycle after each RdEn.
- WrInv index 2, look up 2 -> Hit=0, Target=235 (stale); WrEn+WrInv on index 3 with 129 -> lookup gives 129, Hit=1.
- Same-cycle WrEn index 4=210 with lookup of 4: with LUT_TGT_BYPASS_EN -> Target=210, Hit=1; without -> Target=0, Hit=0; next lookup -> 210, Hit=1 in both builds.
- Write index 6=165, pulse ClearReq mid-run, then pulse ClearReq again 5 cycles into the sweep -> Busy stays high 21 cycles total, writes during sweep dropped, lookup of 6 afterwards -> Hit=0, Target=0.
- Assert Reset_n low mid-sweep for 1 cycle -> outputs return to reset values immediately; Busy then high for a full 16 cycles.
